// File: rtl/topo_pkg.sv
// Shared types for the Kahn topological sorter.
// Default sizing and FSM state encoding.
package topo_pkg;

  localparam int DEF_MAX_NODES  = 1024;
  localparam int DEF_NODE_WIDTH = $clog2(DEF_MAX_NODES);
  localparam int DEF_CNT_WIDTH  = DEF_NODE_WIDTH + 1;

  typedef logic [DEF_NODE_WIDTH-1:0] node_t;
  typedef logic [DEF_CNT_WIDTH-1:0]  cnt_t;

  typedef enum logic [3:0] {
    IDLE,
    SWEEP,
    POP,
    EMIT,
    QUERY,
    WAIT,
    DEC,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/topo_sort_kahn_node_queue.sv
// Circular FIFO of ready nodes with a registered read port.
// Depth need not be a power of two; pointers wrap by compare.
module node_queue #(
  parameter int DEPTH = 1024,
  parameter int W     = 10,
  parameter int CW    = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          overflow_q, overflow_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;

  // Pointer, occupancy, read-data and sticky overflow next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push && full) overflow_d = 1'b1;
      if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
      if (do_pop) begin
        rd_ptr_d  = wrap_inc(rd_ptr_q);
        rd_data_d = mem[rd_ptr_q];
      end
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  // Storage array; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/topo_sort_kahn.sv
// Kahn topological sorter: sweep for roots, then pop,
// emit, query successors and decrement their indegree.
module topo_sort_kahn
  import topo_pkg::*;
#(
  parameter int MAX_NODES  = DEF_MAX_NODES,
  parameter int NODE_WIDTH = $clog2(MAX_NODES),
  parameter int CNT_WIDTH  = NODE_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  node_count,
  output logic [NODE_WIDTH-1:0] indeg_node,
  output logic                  indeg_dec,
  input  logic [NODE_WIDTH-1:0] indeg_degree,
  output logic                  query_valid,
  input  logic                  query_ready,
  output logic [NODE_WIDTH-1:0] query_data,
  input  logic                  reply_valid,
  output logic                  reply_ready,
  input  logic [NODE_WIDTH-1:0] reply_data,
  input  logic                  reply_last,
  input  logic                  reply_no_edges_found,
  output logic                  sorted_valid,
  input  logic                  sorted_ready,
  output logic [NODE_WIDTH-1:0] sorted_node,
  output logic                  busy,
  output logic                  done,
  output logic                  cycle_detected,
  output logic [CNT_WIDTH-1:0]  sorted_count
);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  sweep_idx_q, sweep_idx_d;
  logic [CNT_WIDTH-1:0]  node_count_q, node_count_d;
  logic [CNT_WIDTH-1:0]  sorted_count_q, sorted_count_d;
  logic [NODE_WIDTH-1:0] indeg_node_q, indeg_node_d;
  logic [NODE_WIDTH-1:0] succ_q, succ_d;
  logic                  last_q, last_d;

  logic                  q_clear;
  logic                  q_push;
  logic [NODE_WIDTH-1:0] q_push_data;
  logic                  q_pop;
  logic [NODE_WIDTH-1:0] root;
  logic                  q_empty;
  logic [CNT_WIDTH-1:0]  q_count;
  logic                  q_overflow;

  node_queue #(
    .DEPTH (MAX_NODES),
    .W     (NODE_WIDTH),
    .CW    (CNT_WIDTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (q_clear),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .rd_data   (root),
    .empty     (q_empty),
    .count     (q_count),
    .overflow  (q_overflow)
  );

  // Sort sequencer: next state, datapath and queue controls.
  always_comb begin
    state_d        = state_q;
    sweep_idx_d    = sweep_idx_q;
    node_count_d   = node_count_q;
    sorted_count_d = sorted_count_q;
    indeg_node_d   = indeg_node_q;
    succ_d         = succ_q;
    last_d         = last_q;
    q_clear        = 1'b0;
    q_push         = 1'b0;
    q_push_data    = '0;
    q_pop          = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d        = SWEEP;
          q_clear        = 1'b1;
          sorted_count_d = '0;
          node_count_d   = node_count;
          sweep_idx_d    = '0;
          indeg_node_d   = '0;
        end
      end
      SWEEP: begin
        // Degree returned now belongs to the previous address.
        if (sweep_idx_q != '0 && indeg_degree == '0) begin
          q_push      = 1'b1;
          q_push_data = NODE_WIDTH'(sweep_idx_q - 1'b1);
        end
        if (sweep_idx_q == node_count_q) begin
          state_d = POP;
        end else begin
          sweep_idx_d  = sweep_idx_q + 1'b1;
          indeg_node_d = NODE_WIDTH'(sweep_idx_q + 1'b1);
        end
      end
      POP: begin
        if (q_empty) begin
          state_d = DONE;
        end else begin
          q_pop   = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (sorted_ready) begin
          sorted_count_d = sorted_count_q + 1'b1;
          state_d        = QUERY;
        end
      end
      QUERY: begin
        if (query_ready) state_d = WAIT;
      end
      WAIT: begin
        if (reply_valid) begin
          if (reply_no_edges_found) begin
            state_d = POP;
          end else begin
            succ_d       = reply_data;
            last_d       = reply_last;
            indeg_node_d = reply_data;
            state_d      = DEC;
          end
        end
      end
      DEC: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (indeg_degree == '0) begin
          q_push      = 1'b1;
          q_push_data = succ_q;
        end
        state_d = last_q ? POP : WAIT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sweep_idx_q    <= '0;
      node_count_q   <= '0;
      sorted_count_q <= '0;
      indeg_node_q   <= '0;
      succ_q         <= '0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      sweep_idx_q    <= sweep_idx_d;
      node_count_q   <= node_count_d;
      sorted_count_q <= sorted_count_d;
      indeg_node_q   <= indeg_node_d;
      succ_q         <= succ_d;
      last_q         <= last_d;
    end
  end

  assign indeg_node     = indeg_node_q;
  assign indeg_dec      = (state_q == DEC);
  assign query_valid    = (state_q == QUERY);
  assign query_data     = root;
  assign sorted_valid   = (state_q == EMIT);
  assign sorted_node    = root;
  assign busy           = (state_q != IDLE) && (state_q != DONE);
  assign done           = (state_q == DONE);
  assign cycle_detected = done && (sorted_count_q != node_count_q);
  assign sorted_count   = sorted_count_q;
  assign reply_ready    = (state_q == DEC) ||
                          ((state_q == WAIT) && reply_valid &&
                           reply_no_edges_found);

  // Each node is pushed at most once, so the queue never fills.
  q_bound_a: assert property (
    @(posedge clk) disable iff (!rst_n)
    !q_overflow && (q_count <= CNT_WIDTH'(MAX_NODES))
  );

endmodule

// File: tb/tb_topo_sort_kahn.sv
// Directed bench for topo_sort_kahn with indegree-list
// and adjacency-map models.
module tb_topo_sort_kahn;
  import topo_pkg::*;

  localparam int NW = 10;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] node_count = '0;
  logic [NW-1:0] indeg_node;
  logic          indeg_dec;
  logic [NW-1:0] indeg_degree;
  logic          query_valid;
  logic          query_ready = 1'b1;
  logic [NW-1:0] query_data;
  logic          reply_valid;
  logic          reply_ready;
  logic [NW-1:0] reply_data;
  logic          reply_last;
  logic          reply_no_edges_found;
  logic          sorted_valid;
  logic          sorted_ready = 1'b1;
  logic [NW-1:0] sorted_node;
  logic          busy;
  logic          done;
  logic          cycle_detected;
  logic [CW-1:0] sorted_count;

  int checks = 0;
  int failures = 0;

  logic [NW-1:0] init_deg [16];
  logic [NW-1:0] work [16];
  logic [NW-1:0] adj [16][4];
  int            adj_n [16];
  logic          load = 1'b0;

  logic          rsp_act;
  logic [3:0]    rsp_node;
  int            rsp_idx;
  int            qcount = 0;
  logic [NW-1:0] got [$];

  always #5 clk = ~clk;

  topo_sort_kahn dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .node_count           (node_count),
    .indeg_node           (indeg_node),
    .indeg_dec            (indeg_dec),
    .indeg_degree         (indeg_degree),
    .query_valid          (query_valid),
    .query_ready          (query_ready),
    .query_data           (query_data),
    .reply_valid          (reply_valid),
    .reply_ready          (reply_ready),
    .reply_data           (reply_data),
    .reply_last           (reply_last),
    .reply_no_edges_found (reply_no_edges_found),
    .sorted_valid         (sorted_valid),
    .sorted_ready         (sorted_ready),
    .sorted_node          (sorted_node),
    .busy                 (busy),
    .done                 (done),
    .cycle_detected       (cycle_detected),
    .sorted_count         (sorted_count)
  );

  // Indegree list: registered read, post-decrement value.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) work[i] <= init_deg[i];
    end else if (indeg_dec) begin
      work[indeg_node[3:0]] <= work[indeg_node[3:0]] - 1'b1;
      indeg_degree <= work[indeg_node[3:0]] - 1'b1;
    end
    if (load || !indeg_dec) indeg_degree <= work[indeg_node[3:0]];
  end

  // Adjacency map responder.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_act  <= 1'b0;
      rsp_node <= '0;
      rsp_idx  <= 0;
    end else if (!rsp_act) begin
      if (query_valid && query_ready) begin
        rsp_act  <= 1'b1;
        rsp_node <= query_data[3:0];
        rsp_idx  <= 0;
        qcount   <= qcount + 1;
      end
    end else if (reply_ready) begin
      if (reply_no_edges_found || reply_last) rsp_act <= 1'b0;
      else rsp_idx <= rsp_idx + 1;
    end
  end

  always_comb begin
    reply_valid          = rsp_act;
    reply_no_edges_found = rsp_act && (adj_n[rsp_node] == 0);
    reply_last           = rsp_act && (rsp_idx == adj_n[rsp_node] - 1);
    reply_data           = adj[rsp_node][rsp_idx[1:0]];
  end

  // Sorted stream capture.
  always @(posedge clk) begin
    if (rst_n && sorted_valid && sorted_ready) got.push_back(sorted_node);
  end

  task automatic clear_graph();
    for (int i = 0; i < 16; i++) begin
      init_deg[i] = '0;
      adj_n[i] = 0;
      for (int k = 0; k < 4; k++) adj[i][k] = '0;
    end
  endtask

  task automatic add_edge(input int u, input int v);
    adj[u][adj_n[u]] = NW'(v);
    adj_n[u] = adj_n[u] + 1;
    init_deg[v] = init_deg[v] + 1'b1;
  endtask

  task automatic load_graph();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic start_sort(input int n);
    @(negedge clk);
    node_count = CW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, sorted_valid, query_valid, indeg_dec,
         reply_ready, cycle_detected} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0",
        {busy, done, sorted_valid, query_valid, indeg_dec,
         reply_ready, cycle_detected});
    end
    checks++;
    if (sorted_count !== '0 || indeg_node !== '0 ||
        sorted_node !== '0 || query_data !== '0) begin
      failures++;
      $display("FAIL reset_data cnt=%0d idx=%0d node=%0d q=%0d want=0",
        sorted_count, indeg_node, sorted_node, query_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle busy=%b done=%b want=0/0", busy, done);
    end
  endtask

  task automatic test_diamond(input string tag);
    int exp[4] = '{0, 1, 2, 3};
    int base, cyc, obs;
    clear_graph();
    add_edge(0, 1);
    add_edge(0, 2);
    add_edge(1, 3);
    add_edge(2, 3);
    load_graph();
    sorted_ready = 1'b1;
    base = got.size();
    start_sort(4);
    wait_done(2000, cyc);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done got=%b want=1", tag, done);
    end
    checks++;
    if (got.size() - base != 4) begin
      failures++;
      $display("FAIL %s_len got=%0d want=4", tag, got.size() - base);
    end
    for (int i = 0; i < 4; i++) begin
      obs = (base + i < got.size()) ? int'(got[base + i]) : -1;
      checks++;
      if (obs != exp[i]) begin
        failures++;
        $display("FAIL %s_node%0d got=%0d want=%0d", tag, i, obs, exp[i]);
      end
    end
    checks++;
    if (sorted_count !== CW'(4) || cycle_detected !== 1'b0) begin
      failures++;
      $display("FAIL %s_summary cnt=%0d cyc=%b want=4/0",
        tag, sorted_count, cycle_detected);
    end
  endtask

  task automatic test_cycle();
    int base, cyc;
    clear_graph();
    add_edge(0, 1);
    add_edge(1, 2);
    add_edge(2, 1);
    load_graph();
    base = got.size();
    start_sort(3);
    wait_done(2000, cyc);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL cycle_done got=%b want=1", done);
    end
    checks++;
    if (got.size() - base != 1 ||
        (got.size() > base && got[base] !== NW'(0))) begin
      failures++;
      $display("FAIL cycle_stream len=%0d want=1 (node 0)",
        got.size() - base);
    end
    checks++;
    if (sorted_count !== CW'(1) || cycle_detected !== 1'b1) begin
      failures++;
      $display("FAIL cycle_summary cnt=%0d cyc=%b want=1/1",
        sorted_count, cycle_detected);
    end
  endtask

  task automatic test_empty();
    int base, cyc;
    clear_graph();
    load_graph();
    base = got.size();
    start_sort(0);
    wait_done(10, cyc);
    checks++;
    if (done !== 1'b1 || cyc + 1 > 3) begin
      failures++;
      $display("FAIL empty_latency done=%b cycles=%0d want done<=3",
        done, cyc + 1);
    end
    checks++;
    if (sorted_count !== '0 || cycle_detected !== 1'b0) begin
      failures++;
      $display("FAIL empty_summary cnt=%0d cyc=%b want=0/0",
        sorted_count, cycle_detected);
    end
    checks++;
    if (got.size() != base) begin
      failures++;
      $display("FAIL empty_stream beats=%0d want=0", got.size() - base);
    end
  endtask

  task automatic test_backpressure();
    int base, cyc;
    logic [NW-1:0] held;
    clear_graph();
    add_edge(0, 1);
    add_edge(1, 2);
    load_graph();
    sorted_ready = 1'b0;
    base = got.size();
    start_sort(3);
    for (int b = 0; b < 3; b++) begin
      for (int t = 0; t < 200 && !sorted_valid; t++) @(negedge clk);
      held = sorted_node;
      checks++;
      if (sorted_valid !== 1'b1 || held !== NW'(b)) begin
        failures++;
        $display("FAIL bp_beat%0d valid=%b node=%0d want=1/%0d",
          b, sorted_valid, held, b);
      end
      for (int s = 0; s < 5; s++) begin
        @(negedge clk);
        checks++;
        if (sorted_valid !== 1'b1 || sorted_node !== held) begin
          failures++;
          $display("FAIL bp_hold%0d valid=%b node=%0d want=1/%0d",
            b, sorted_valid, sorted_node, held);
        end
      end
      sorted_ready = 1'b1;
      @(negedge clk);
      sorted_ready = 1'b0;
    end
    wait_done(2000, cyc);
    sorted_ready = 1'b1;
    checks++;
    if (done !== 1'b1 || sorted_count !== CW'(3) ||
        cycle_detected !== 1'b0) begin
      failures++;
      $display("FAIL bp_summary done=%b cnt=%0d cyc=%b want=1/3/0",
        done, sorted_count, cycle_detected);
    end
    checks++;
    if (got.size() - base != 3) begin
      failures++;
      $display("FAIL bp_len got=%0d want=3", got.size() - base);
    end
  endtask

  task automatic test_isolated();
    int base, cyc, q0, obs;
    clear_graph();
    load_graph();
    base = got.size();
    q0 = qcount;
    start_sort(5);
    wait_done(2000, cyc);
    for (int i = 0; i < 5; i++) begin
      obs = (base + i < got.size()) ? int'(got[base + i]) : -1;
      checks++;
      if (obs != i) begin
        failures++;
        $display("FAIL iso_node%0d got=%0d want=%0d", i, obs, i);
      end
    end
    checks++;
    if (qcount - q0 != 5) begin
      failures++;
      $display("FAIL iso_queries got=%0d want=5", qcount - q0);
    end
    checks++;
    if (done !== 1'b1 || sorted_count !== CW'(5) ||
        cycle_detected !== 1'b0) begin
      failures++;
      $display("FAIL iso_summary done=%b cnt=%0d cyc=%b want=1/5/0",
        done, sorted_count, cycle_detected);
    end
  endtask

  task automatic test_reset_mid();
    clear_graph();
    add_edge(0, 1);
    add_edge(0, 2);
    add_edge(1, 3);
    add_edge(2, 3);
    load_graph();
    sorted_ready = 1'b1;
    start_sort(4);
    for (int t = 0; t < 200 && !indeg_dec; t++) @(negedge clk);
    checks++;
    if (indeg_dec !== 1'b1) begin
      failures++;
      $display("FAIL mid_reach_dec got=%b want=1", indeg_dec);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sorted_valid, query_valid, indeg_dec,
         reply_ready, cycle_detected} !== 7'b0 ||
        sorted_count !== '0 || indeg_node !== '0 ||
        sorted_node !== '0) begin
      failures++;
      $display("FAIL mid_reset flags=%b cnt=%0d idx=%0d node=%0d want=0",
        {busy, done, sorted_valid, query_valid, indeg_dec,
         reply_ready, cycle_detected},
        sorted_count, indeg_node, sorted_node);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_diamond("rerun");
  endtask

  initial begin
    clear_graph();
    test_reset();
    test_diamond("diamond");
    test_cycle();
    test_empty();
    test_backpressure();
    test_isolated();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
